alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the datapath ALU. It executes one 8-operation instruction at a time on NBIT-wide operands with correct V/C/N/Z flags. Results are registered; shifts take a variable amount (0..NBIT-1) and run multi-cycle. It sits between the register-file read stage and write-back, decoupled on both sides by valid/ready handshakes.

## Interface
- NBIT, 16: operand/result width (≥4).
- SHW, $clog2(NBIT): shift-amount width, taken from B[SHW-1:0].
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  ALU can accept; high only in IDLE.
- A, B  in  NBIT  operands (B supplies shift amount for shifts).
- Sel  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 SHL, 111 SHR (logical).
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- num_out  out  NBIT  result.
- v, c, n, z  out  1 each  overflow, carry, negative, zero.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset → IDLE; num_out=0, v=c=n=z=0, out_valid=0. in_ready=1 after reset.
- Accept = in_valid & in_ready. Operands and Sel are latched on accept; later input changes are ignored.
- IDLE, accept, non-shift op: compute and register result+flags; → DONE.
- IDLE, accept, shift with amt=B[SHW-1:0]:
  - amt=0: num_out=A, c=0; → DONE.
  - amt≠0: load working reg=A, counter=amt; → SHIFT.
- SHIFT: shift 1 bit per cycle (zero fill) and decrement the counter. c = last bit shifted out. At counter 1→0, register the final result and flags; → DONE.
- DONE: out_valid=1; outputs held stable until out_ready=1, then → IDLE.
- Arithmetic is NBIT-bit with wrap.
  - ADD: c = carry out; v = (A[msb]==B[msb]) & (R[msb]!=A[msb]).
  - SUB: R=A-B; c = borrow (A<B unsigned); v = (A[msb]!=B[msb]) & (R[msb]!=A[msb]).
  - AND/OR/XOR are bitwise. NOT is ~A and ignores B. For all logic ops, c=v=0.
  - Shifts: v=0.
- All ops: n=R[msb], z=(R==0). Flags are fully assigned on every completion; no latched or sticky bits.
- Flags and num_out change only on completion; they are held in IDLE and SHIFT.
- rst_n asserted mid-SHIFT or mid-DONE: immediate return to reset values. The in-flight op is discarded.

## Timing
- Non-shift: out_valid rises 1 cycle after the accept edge.
- Shift by k≥1: out_valid rises k+1 cycles after accept. k=0: 1 cycle.
- Minimum 2 cycles per op: accept, DONE cycle, then IDLE. No accept while DONE or SHIFT.
- in_ready is combinational from state only. There is no combinational path from in_valid to out_valid, or from out_ready to in_ready.

## Configuration
- ALU_BARREL_EN defined: SHL/SHR complete in one cycle via a barrel shifter. SHIFT state is unused, so all ops have 1-cycle latency. c = bit A[NBIT-amt] (SHL) or A[amt-1] (SHR); c=0 when amt=0.
- Undefined: iterative 1-bit/cycle shifter as above (smaller area).

## Structure
- Shared package alu_pkg: opcode localparams (OP_ADD..OP_SHR), state enum, flag-bit index constants.
- One sub-module: alu_flags. It is combinational and takes op, A, B, R, carry-in-from-shift, producing v/c/n/z. It is reused in both shift modes.

## Test plan
- NBIT=16, ADD 0x7FFF+0x0001 → num_out=0x8000, v=1, c=0, n=1, z=0; out_valid 1 cycle after accept.
- SUB 0x0003-0x0005 → 0xFFFE, c=1, v=0, n=1; SUB 0x1234-0x1234 → 0x0000, z=1, c=0.
- SHL A=0x8001 B=3 (iterative) → 0x0008, c=0, out_valid 4 cycles after accept. SHR A=0x0005 B=1 → 0x0002, c=1. B=0 → A unchanged, 1 cycle.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → num_out/flags stable, in_ready=0, new in_valid ignored. Release → IDLE next cycle.
- Reset mid-SHIFT (SHL by 10, rst_n low at cycle 4) → all outputs 0, in_ready=1 after release, next ADD 2+2 → 4.
- XOR 0xAAAA^0xAAAA → 0, z=1, c=v=0. NOT 0x0000 → 0xFFFF, n=1. With ALU_BARREL_EN, SHL by 15 → 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the alu_seq block: opcodes, FSM states, flag indices.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bit positions inside the packed {v,c,n,z} flag vector
  localparam int FLG_V = 3;
  localparam int FLG_C = 2;
  localparam int FLG_N = 1;
  localparam int FLG_Z = 0;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bus of alu_seq: operand handshake in, result handshake out.
interface alu_seq_if #(
  parameter int NBIT = 16
) ();
  logic            in_valid;
  logic            in_ready;
  logic [NBIT-1:0] A;
  logic [NBIT-1:0] B;
  logic [2:0]      Sel;
  logic            out_valid;
  logic            out_ready;
  logic [NBIT-1:0] num_out;
  logic            v;
  logic            c;
  logic            n;
  logic            z;

  // Producer of operations / consumer of results
  modport master (
    output in_valid, A, B, Sel, out_ready,
    input  in_ready, out_valid, num_out, v, c, n, z
  );

  // The ALU itself
  modport slave (
    input  in_valid, A, B, Sel, out_ready,
    output in_ready, out_valid, num_out, v, c, n, z
  );
endinterface

// File: rtl/alu_flags.sv
// Combinational V/C/N/Z generation for a finished result. Shift carry comes in
// from whichever shifter produced R, so the same block serves both shift modes.
module alu_flags
  import alu_pkg::*;
#(
  parameter int NBIT = 16
) (
  input  logic [2:0]      op,
  input  logic [NBIT-1:0] a,
  input  logic [NBIT-1:0] b,
  input  logic [NBIT-1:0] r,
  input  logic            shc,
  output logic [3:0]      flags
);
  localparam int MSB = NBIT - 1;

  // Carry out of the top adder bit: majority of a, b and the carry into the msb,
  // where that carry-in is recovered as r^a^b at the msb.
  logic add_c;
  assign add_c = (a[MSB] & b[MSB]) | ((a[MSB] | b[MSB]) & ~r[MSB]);

  // Per-op flag selection; logic ops leave c/v cleared
  always_comb begin
    flags        = '0;
    flags[FLG_N] = r[MSB];
    flags[FLG_Z] = (r == '0);
    case (op)
      OP_ADD: begin
        flags[FLG_C] = add_c;
        flags[FLG_V] = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
      end
      OP_SUB: begin
        flags[FLG_C] = (a < b);
        flags[FLG_V] = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
      end
      OP_SHL, OP_SHR: flags[FLG_C] = shc;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked 8-op ALU with registered result and flags.
// Shifts are iterative (1 bit/cycle) by default; define ALU_BARREL_EN to make
// SHL/SHR single-cycle through a barrel shifter.
module alu_seq
  import alu_pkg::*;
#(
  parameter int NBIT = 16,
  parameter int SHW  = $clog2(NBIT)
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  localparam int MSB = NBIT - 1;

  state_t          state, nxt;
  logic            accept;
  logic [SHW-1:0]  amt;
  logic [NBIT-1:0] r_idle;
  logic            shc_idle;
  logic [2:0]      fl_op;
  logic [NBIT-1:0] fl_r;
  logic            fl_shc;
  logic [3:0]      fl;
  logic [NBIT-1:0] num_q;
  logic [3:0]      flg_q;
  logic            shift_start;
  logic            last_step;

  assign accept = bus.in_valid & bus.in_ready;
  assign amt    = bus.B[SHW-1:0];

`ifdef ALU_BARREL_EN
  // One extra bit on the shifted-out side captures the carry; amt=0 yields c=0
  logic [NBIT:0] shl_ext;
  logic [NBIT:0] shr_ext;
  assign shl_ext     = {1'b0, bus.A} << amt;
  assign shr_ext     = {bus.A, 1'b0} >> amt;
  assign shift_start = 1'b0;
  assign last_step   = 1'b1;
  assign fl_op       = bus.Sel;
  assign fl_r        = r_idle;
  assign fl_shc      = shc_idle;
`else
  logic [2:0]      op_q;
  logic [NBIT-1:0] work;
  logic [NBIT-1:0] step;
  logic            step_bit;
  logic [SHW-1:0]  cnt;

  assign shift_start = is_shift(bus.Sel) && (amt != '0);
  assign last_step   = (cnt == SHW'(1));

  // One-bit shift of the working register and the bit falling out of it
  always_comb begin
    if (op_q == OP_SHL) begin
      step     = {work[MSB-1:0], 1'b0};
      step_bit = work[MSB];
    end else begin
      step     = {1'b0, work[MSB:1]};
      step_bit = work[0];
    end
  end

  // Flags see the latched shift while shifting, the live request otherwise
  assign fl_op  = (state == ST_SHIFT) ? op_q     : bus.Sel;
  assign fl_r   = (state == ST_SHIFT) ? step     : r_idle;
  assign fl_shc = (state == ST_SHIFT) ? step_bit : shc_idle;

  // Iterative shifter: load on accept, then shift and count down
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= OP_ADD;
      work <= '0;
      cnt  <= '0;
    end else if (state == ST_IDLE && accept && shift_start) begin
      op_q <= bus.Sel;
      work <= bus.A;
      cnt  <= amt;
    end else if (state == ST_SHIFT) begin
      work <= step;
      cnt  <= cnt - SHW'(1);
    end
  end
`endif

  // Single-cycle result for the op presented at accept
  always_comb begin
    r_idle   = '0;
    shc_idle = 1'b0;
    case (bus.Sel)
      OP_ADD: r_idle = bus.A + bus.B;
      OP_SUB: r_idle = bus.A - bus.B;
      OP_AND: r_idle = bus.A & bus.B;
      OP_OR:  r_idle = bus.A | bus.B;
      OP_XOR: r_idle = bus.A ^ bus.B;
      OP_NOT: r_idle = ~bus.A;
`ifdef ALU_BARREL_EN
      OP_SHL: begin
        r_idle   = shl_ext[MSB:0];
        shc_idle = shl_ext[NBIT];
      end
      OP_SHR: begin
        r_idle   = shr_ext[NBIT:1];
        shc_idle = shr_ext[0];
      end
`else
      // Only the amt=0 case completes here; nonzero amounts go to SHIFT
      OP_SHL, OP_SHR: r_idle = bus.A;
`endif
      default: r_idle = '0;
    endcase
  end

  alu_flags #(.NBIT(NBIT)) u_flags (
    .op    (fl_op),
    .a     (bus.A),
    .b     (bus.B),
    .r     (fl_r),
    .shc   (fl_shc),
    .flags (fl)
  );

  // Result/flag register: written only when an op completes, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q <= '0;
      flg_q <= '0;
    end else if ((state == ST_IDLE && accept && !shift_start) ||
                 (state == ST_SHIFT && last_step)) begin
      num_q <= fl_r;
      flg_q <= fl;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  // FSM next-state logic
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (accept) nxt = shift_start ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (last_step) nxt = ST_DONE;
      ST_DONE:  if (bus.out_ready) nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake signals decode state only
  always_comb begin
    bus.in_ready  = (state == ST_IDLE);
    bus.out_valid = (state == ST_DONE);
  end

  assign bus.num_out = num_q;
  assign bus.v       = flg_q[FLG_V];
  assign bus.c       = flg_q[FLG_C];
  assign bus.n       = flg_q[FLG_N];
  assign bus.z       = flg_q[FLG_Z];

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes expected results, monitor pops
// and compares on each output transfer, including latency from accept.
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct {
    logic [15:0] num;
    logic [3:0]  vcnz;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   ignore_out = 1'b0;
  bit   ov_d = 1'b0;
  exp_t sbq[$];

  alu_seq_if #(.NBIT(16)) bus ();

  alu_seq #(.NBIT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected latency of a shift by k in the current build
  function automatic int slat(input int k);
`ifdef ALU_BARREL_EN
    return 1;
`else
    return (k == 0) ? 1 : k + 1;
`endif
  endfunction

  // Monitor: latency check when out_valid rises, value check on each transfer
  always @(negedge clk) begin
    if (!rst_n || ignore_out) begin
      ov_d = 1'b0;
    end else begin
      if (bus.out_valid && !ov_d) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got %0h expected none", bus.num_out);
        end else begin
          chk("latency", cyc - sbq[0].acc + 1, sbq[0].lat);
        end
      end
      if (bus.out_valid && bus.out_ready && sbq.size() > 0) begin
        chk("num_out", bus.num_out, sbq[0].num);
        chk("vcnz", {bus.v, bus.c, bus.n, bus.z}, sbq[0].vcnz);
        void'(sbq.pop_front());
      end
      ov_d = bus.out_valid;
    end
  end

  // Present one op, wait for accept, then scramble operands to prove latching
  task automatic issue(input logic [2:0] sel, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] r, input logic [3:0] vcnz, input int lat,
                       input bit push);
    exp_t e;
    int   w;
    @(negedge clk);
    bus.Sel = sel;
    bus.A = a;
    bus.B = b;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end else if (push) begin
      e.num = r;
      e.vcnz = vcnz;
      e.lat = lat;
      e.acc = cyc + 1;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A = 16'hDEAD;
    bus.B = 16'hBEEF;
    bus.Sel = OP_SUB;
  endtask

  task automatic drain();
    int w = 0;
    while ((sbq.size() != 0 || !bus.in_ready) && w < 100) begin
      @(negedge clk);
      w++;
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.Sel = OP_ADD;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_num", bus.num_out, 16'h0000);
    chk("rst_flags", {bus.v, bus.c, bus.n, bus.z}, 4'b0000);
    chk("rst_ovalid", bus.out_valid, 1'b0);
    chk("rst_iready", bus.in_ready, 1'b1);
    rst_n = 1'b1;

    //     op      A        B        R        vcnz     lat
    issue(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b1010, 1, 1);
    issue(OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 4'b0110, 1, 1);
    issue(OP_SUB, 16'h1234, 16'h1234, 16'h0000, 4'b0001, 1, 1);
    issue(OP_SHL, 16'h8001, 16'h0003, 16'h0008, 4'b0000, slat(3), 1);
    issue(OP_SHR, 16'h0005, 16'h0001, 16'h0002, 4'b0100, slat(1), 1);
    issue(OP_SHL, 16'h1234, 16'h0010, 16'h1234, 4'b0000, slat(0), 1);
    issue(OP_XOR, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0001, 1, 1);
    issue(OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1, 1);
    issue(OP_OR,  16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000, 1, 1);
    issue(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b0101, 1, 1);
    issue(OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b1000, 1, 1);
    issue(OP_SHL, 16'h0001, 16'h000F, 16'h8000, 4'b0010, slat(15), 1);
    issue(OP_SHR, 16'hC000, 16'h000F, 16'h0001, 4'b0100, slat(15), 1);
    drain();

    // Backpressure: result held in DONE, new requests refused
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    issue(OP_ADD, 16'h0100, 16'h0200, 16'h0300, 4'b0000, 1, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.Sel = OP_SUB;
      bus.A = 16'h0009;
      bus.B = 16'h0001;
      chk("bp_iready", bus.in_ready, 1'b0);
      chk("bp_ovalid", bus.out_valid, 1'b1);
      chk("bp_num", bus.num_out, 16'h0300);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_iready", bus.in_ready, 1'b1);
    chk("bp_release_ovalid", bus.out_valid, 1'b0);

    // Leave nonzero outputs behind so reset has something to clear
    issue(OP_NOT, 16'h0000, 16'h1234, 16'hFFFF, 4'b0010, 1, 1);
    drain();

    // Reset in the middle of a long shift
    ignore_out = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    issue(OP_SHL, 16'h00FF, 16'h000A, 16'h0000, 4'b0000, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
`ifndef ALU_BARREL_EN
    chk("shift_hold_num", bus.num_out, 16'hFFFF);
    chk("shift_iready", bus.in_ready, 1'b0);
`endif
    rst_n = 1'b0;
    #1;
    chk("midrst_num", bus.num_out, 16'h0000);
    chk("midrst_flags", {bus.v, bus.c, bus.n, bus.z}, 4'b0000);
    chk("midrst_ovalid", bus.out_valid, 1'b0);
    chk("midrst_iready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    ignore_out = 1'b0;
    @(negedge clk);
    chk("postrst_iready", bus.in_ready, 1'b1);
    issue(OP_ADD, 16'h0002, 16'h0002, 16'h0004, 4'b0000, 1, 1);
    drain();

    chk("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
